// File: rtl/dmem_byteen_model.sv
// -----------------------------------------------------------------------------
// dmem_byteen_model
//
// Data memory for the CPU test harness. It is a word array with per-byte write
// enables, a single-outstanding request/response handshake, a configurable
// response latency and address range checking. After reset a hardware sweep
// writes zero to every word, so the block can also serve as scratch RAM.
//
// Parameters
//   DW     data width in bits (multiple of 8), BEW = DW/8 byte lanes
//   AW     byte-address width
//   DEPTH  number of DW-bit words (power of two, >= 2)
//   BASE   byte address of word 0 (aligned to BEW)
//   LAT    cycles from request accept to rsp_valid (>= 1)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   req_valid   request present
//   req_ready   block can accept a request
//   req_addr    byte address; the low log2(BEW) bits are ignored
//   req_byteen  lane write enables; all-zero means read
//   req_wdata   write data, lane i = bits [8i+7:8i]
//   req_pc      issuing instruction address, used only by the trace
//   rsp_valid   one-cycle response strobe for reads and writes
//   rsp_rdata   read word; zero for writes and errors; held until next response
//   rsp_err     request was out of range; held until next response
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_valid while req_ready is low is ignored (no
// buffering; the requester holds its request). Exactly one response strobe
// follows each transfer, LAT cycles after the transfer edge, unless a reset
// intervenes, in which case the pending response is dropped.
//
// Configuration macro
//   DMEM_TRACE_EN  when defined, every committed in-range write prints one
//                  trace line at its commit edge. Sweep writes and
//                  out-of-range writes are not printed.
//
// FSM state is held in 'state' (CLEAR -> IDLE -> BUSY -> IDLE) for checkers.
// -----------------------------------------------------------------------------
module dmem_byteen_model #(
    parameter int            DW    = 32,
    parameter int            AW    = 32,
    parameter int            DEPTH = 4096,
    parameter logic [AW-1:0] BASE  = '0,
    parameter int            LAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW/8-1:0] req_byteen,
    input  logic [DW-1:0]   req_wdata,
    input  logic [31:0]     req_pc,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
);

    localparam int BEW = DW / 8;
    localparam int LSB = (BEW > 1) ? $clog2(BEW) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] clr_idx;
    logic [CW-1:0] cnt;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   diff;
    logic [AW-1:0] word_off;
    logic          oor;
    logic          acc;
    logic          is_wr;
    logic [IW-1:0] widx;
    logic [DW-1:0] cur_word;
    logic [DW-1:0] merged;
    logic [DW-1:0] rsp_word;
    logic [DW-1:0] pend_rdata;
    logic          pend_err;

    assign req_ready = (state == ST_IDLE);

    // Address decode. The subtraction carries one extra bit so an address
    // below BASE shows up as a borrow instead of wrapping into the array.
    always_comb begin
        diff     = {1'b0, req_addr} - {1'b0, BASE};
        word_off = diff[AW-1:0] >> LSB;
        oor      = diff[AW] | (word_off >= AW'(DEPTH));
        widx     = word_off[IW-1:0];
        cur_word = mem[widx];
        is_wr    = |req_byteen;
        acc      = req_valid & req_ready & ~reset;
        merged   = cur_word;
        for (int i = 0; i < BEW; i++) begin
            if (req_byteen[i]) begin
                merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
        // Writes and errors respond with a zero word.
        rsp_word = (oor | is_wr) ? '0 : cur_word;
    end

    // Control FSM and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_idx    <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (acc) begin
                        if (LAT == 1) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_word;
                            rsp_err   <= oor;
                        end else begin
                            // Read data is captured now so later writes
                            // cannot change this response.
                            state      <= ST_BUSY;
                            cnt        <= CW'(LAT - 1);
                            pend_rdata <= rsp_word;
                            pend_err   <= oor;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == CW'(1)) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Array writes: the clear sweep and accepted in-range writes never
    // coincide because req_ready is low during the sweep.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (acc && is_wr && !oor) begin
            mem[widx] <= merged;
        end
    end

`ifdef DMEM_TRACE_EN
    logic [AW-1:0] aligned_addr;
    assign aligned_addr = req_addr & ~AW'(BEW - 1);

    always_ff @(posedge clk) begin
        if (acc && is_wr && !oor) begin
            $display("%d@%h: *%h <= %h", $time, req_pc, aligned_addr, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_byteen_model.sv
// -----------------------------------------------------------------------------
// tb_dmem_byteen_model
//
// Two instances, both DEPTH=16:
//   index 0: BASE=0,      LAT=1 (back-to-back traffic, byte-lane merging)
//   index 1: BASE=0x1000, LAT=3 (latency/ready timing, range checks, reset
//            during BUSY)
// Driver tasks push expected responses {due_cycle, err, rdata} into a
// per-instance queue; a monitor per instance pops and compares whenever
// rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_byteen_model;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int EW    = 65;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic [3:0]  req_byteen [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] req_pc     [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    dmem_byteen_model #(.DW(32), .AW(32), .DEPTH(16), .BASE(32'h0), .LAT(LAT_A)) u_dut_a (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .req_byteen(req_byteen[0]),
        .req_wdata (req_wdata[0]),
        .req_pc    (req_pc[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_byteen_model #(.DW(32), .AW(32), .DEPTH(16), .BASE(32'h1000), .LAT(LAT_B)) u_dut_b (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .req_byteen(req_byteen[1]),
        .req_wdata (req_wdata[1]),
        .req_pc    (req_pc[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    // Scoreboard
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    logic [EW-1:0] e0;
    always @(negedge clk) begin
        if (!reset[0]) begin
            if (rsp_valid[0]) begin
                if (exp_q0.size() == 0) begin
                    miss("unexpected_rsp_a: rsp_valid=1, expected none");
                end else begin
                    e0 = exp_q0.pop_front();
                    chk("rdata_a", rsp_rdata[0], e0[31:0]);
                    chk("err_a", {31'b0, rsp_err[0]}, {31'b0, e0[32]});
                    chk("rsp_cycle_a", cyc, e0[64:33]);
                end
            end else if (exp_q0.size() > 0 && int'(exp_q0[0][64:33]) < cyc) begin
                e0 = exp_q0.pop_front();
                miss("missing_rsp_a: rsp_valid=0, expected 1");
            end
        end
    end

    logic [EW-1:0] e1;
    always @(negedge clk) begin
        if (!reset[1]) begin
            if (rsp_valid[1]) begin
                if (exp_q1.size() == 0) begin
                    miss("unexpected_rsp_b: rsp_valid=1, expected none");
                end else begin
                    e1 = exp_q1.pop_front();
                    chk("rdata_b", rsp_rdata[1], e1[31:0]);
                    chk("err_b", {31'b0, rsp_err[1]}, {31'b0, e1[32]});
                    chk("rsp_cycle_b", cyc, e1[64:33]);
                end
            end else if (exp_q1.size() > 0 && int'(exp_q1[0][64:33]) < cyc) begin
                e1 = exp_q1.pop_front();
                miss("missing_rsp_b: rsp_valid=0, expected 1");
            end
        end
    end

    // Driver: called just after a negedge. Holds req_valid until ready, then
    // pushes the expected response for the accept edge that follows.
    task automatic issue(input int d, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n;
        int due;
        n = 0;
        req_valid[d]  = 1'b1;
        req_addr[d]   = addr;
        req_byteen[d] = be;
        req_wdata[d]  = wd;
        req_pc[d]     = 32'h3000 + addr;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            miss("ready_timeout");
            req_valid[d] = 1'b0;
            return;
        end
        due = cyc + ((d == 0) ? LAT_A : LAT_B);
        if (d == 0) exp_q0.push_back({due[31:0], ee, er});
        else        exp_q1.push_back({due[31:0], ee, er});
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Counts, over a fixed window, cycles with ready low and with rsp_valid high.
    task automatic count_window(input int d, output int ready_low, output int valids);
        ready_low = 0;
        valids    = 0;
        for (int k = 0; k < 40; k++) begin
            if (!req_ready[d]) ready_low++;
            if (rsp_valid[d])  valids++;
            @(negedge clk);
        end
    endtask

    initial begin
        int rl0;
        int rl1;
        int rv0;
        int rv1;
        int n;
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            req_byteen[d] = '0;
            req_wdata[d]  = '0;
            req_pc[d]     = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'b0, req_ready[d]}, 32'd0);
            chk("reset_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
            chk("reset_rdata", rsp_rdata[d], 32'd0);
            chk("reset_err", {31'b0, rsp_err[d]}, 32'd0);
        end

        // Clear sweep: ready low for exactly DEPTH cycles after release
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        fork
            count_window(0, rl0, rv0);
            count_window(1, rl1, rv1);
        join
        chk("sweep_ready_low_a", rl0, 32'd16);
        chk("sweep_ready_low_b", rl1, 32'd16);
        chk("sweep_no_rsp_a", rv0, 32'd0);
        chk("sweep_no_rsp_b", rv1, 32'd0);

        // Every word reads back zero after the sweep
        for (int i = 0; i < 16; i++) issue(0, 32'(4 * i), 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i += 5) issue(1, 32'h1000 + 32'(4 * i), 4'h0, 32'h0, 32'h0, 1'b0);

        // Byte-lane merging on the LAT=1 instance (back-to-back)
        issue(0, 32'h4, 4'hF, 32'h11223344, 32'h0, 1'b0);
        issue(0, 32'h4, 4'h3, 32'hAABBCCDD, 32'h0, 1'b0);
        issue(0, 32'h6, 4'h0, 32'h0, 32'h1122CCDD, 1'b0);
        issue(0, 32'h8, 4'hA, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(0, 32'h8, 4'h0, 32'hFFFFFFFF, 32'hDE00BE00, 1'b0);
        issue(0, 32'h8, 4'h4, 32'h00770000, 32'h0, 1'b0);
        issue(0, 32'hB, 4'h0, 32'h0, 32'hDE77BE00, 1'b0);
        // Read samples at its accept edge; the following write must not leak in
        issue(0, 32'h4, 4'h0, 32'h0, 32'h1122CCDD, 1'b0);
        issue(0, 32'h4, 4'hC, 32'h99880000, 32'h0, 1'b0);
        issue(0, 32'h4, 4'h0, 32'h0, 32'h9988CCDD, 1'b0);
        // Range edges at BASE=0
        issue(0, 32'h3C, 4'hF, 32'h0BADBEEF, 32'h0, 1'b0);
        issue(0, 32'h40, 4'hF, 32'h12345678, 32'h0, 1'b1);
        issue(0, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 1'b1);
        issue(0, 32'h3C, 4'h0, 32'h0, 32'h0BADBEEF, 1'b0);
        issue(0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // LAT=3: ready low for the two cycles after accept, back on the third
        issue(1, 32'h1008, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
        chk("lat_ready_n1", {31'b0, req_ready[1]}, 32'd0);
        @(negedge clk);
        chk("lat_ready_n2", {31'b0, req_ready[1]}, 32'd0);
        @(negedge clk);
        chk("lat_ready_n3", {31'b0, req_ready[1]}, 32'd1);
        chk("lat_rsp_n3", {31'b0, rsp_valid[1]}, 32'd1);
        issue(1, 32'h1008, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Range checks with BASE=0x1000
        issue(1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1, 32'h103C, 4'hF, 32'h12345678, 32'h0, 1'b0);
        issue(1, 32'h1040, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1'b1);
        issue(1, 32'h0000, 4'hF, 32'h77777777, 32'h0, 1'b1);
        issue(1, 32'h1000, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        issue(1, 32'h103C, 4'h0, 32'h0, 32'h12345678, 1'b0);
        issue(1, 32'h103F, 4'h0, 32'h0, 32'h12345678, 1'b0);

        // Reset during BUSY: response dropped, sweep restarts, word cleared
        n = 0;
        while (!req_ready[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'h1008;
        req_byteen[1] = 4'hF;
        req_wdata[1]  = 32'h00000055;
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1]     = 1'b1;
        @(negedge clk);
        reset[1] = 1'b0;
        count_window(1, rl1, rv1);
        chk("busy_reset_ready_low", rl1, 32'd16);
        chk("busy_reset_no_rsp", rv1, 32'd0);
        issue(1, 32'h1008, 4'h0, 32'h0, 32'h0, 1'b0);
        issue(1, 32'h103C, 4'h0, 32'h0, 32'h0, 1'b0);

        // Drain
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", exp_q0.size(), 32'd0);
        chk("drain_b", exp_q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
